imem_responder: RTL
===================

Name: imem_responder

Overview:
- Responder end of the instruction-fetch interface: the fetch stage issues PC requests, and this block returns instruction words from on-chip instruction memory.
- Request/response handshake with one-cycle latency and a single-entry output register that supports back-pressure.
- Flush input kills a pending response on a taken branch.
- Byte-stream program-loader port (the memory's writer) fills the memory at boot; fetches are blocked while loading.

Parameters:
- MEM_WORDS, 8192, instruction memory depth in 32-bit words; must be a power of two.
- CNT_W, 16, width of the loader word count.
- NOP_INSTR, 32'h00000013, word returned on an error response (addi x0,x0,0).

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- ReqValidF  in  1  fetch request valid.
- ReqAddrF  in  32  fetch byte address (PC).
- ReqReadyF  out  1  request accepted this cycle when ReqValidF is also high.
- FlushF  in  1  discard the pending response (branch taken).
- RspValidF  out  1  response valid.
- RspInstrF  out  32  instruction word.
- RspErrF  out  1  response flags a misaligned or out-of-range address.
- RspReadyF  in  1  consumer accepts the response.
- LdStart  in  1  start-load pulse.
- LdBase  in  32  load start byte address; bits [1:0] ignored.
- LdCount  in  CNT_W  number of words to load.
- LdValid  in  1  load byte valid.
- LdByte  in  8  load data byte, little-endian within each word.
- LdReady  out  1  load byte accepted this cycle when LdValid is also high.
- Loading  out  1  high while in S_LOAD.
- LdDone  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset (async, reset_n=0):
  - state=S_SERVE.
  - RspValidF=0, RspInstrF=0, RspErrF=0.
  - LdDone=0, Loading=0, LdReady=0.
  - Byte counter and pointer cleared.
  - Memory contents are not cleared.
  - Reset asserted mid-load abandons the load, and the partial word is discarded.
- States:
  - S_SERVE: fetches are served.
  - S_LOAD: the loader owns the memory.
- ReqReadyF = (state==S_SERVE) && !LdStart && (!RspValidF || RspReadyF || FlushF). This is combinational.
- Accept (ReqValidF && ReqReadyF):
  - Next cycle RspValidF=1.
  - RspInstrF = mem[ReqAddrF[31:2]].
  - Latency is exactly 1 cycle.
- Error cases, each giving RspErrF=1 and RspInstrF=NOP_INSTR:
  - ReqAddrF[31:2] >= MEM_WORDS.
  - ReqAddrF[1:0] != 0.
- Hold: while RspValidF=1 && RspReadyF=0 && FlushF=0, RspValidF, RspInstrF and RspErrF stay stable.
- Pop: RspReadyF=1 with no new accept gives RspValidF=0 next cycle.
- Flush:
  - FlushF=1 with no accept gives RspValidF=0 next cycle.
  - FlushF=1 with a same-cycle accept means the new request's response replaces the old one; the old response is never presented again.
- Pending response in S_LOAD: it stays in the output register and drains normally via RspReadyF or FlushF.
- LdStart in S_SERVE:
  - LdStart takes priority over a same-cycle request; the request is not accepted.
  - ptr = LdBase[31:2] mod MEM_WORDS, remaining = LdCount, byte counter = 0.
  - If LdCount == 0: stay in S_SERVE and pulse LdDone the next cycle.
  - Otherwise go to S_LOAD the next cycle.
- LdStart in S_LOAD is ignored.
- In S_LOAD:
  - LdReady=1 and Loading=1.
  - Each accepted byte goes to lane [8*bc+7:8*bc], then bc increments.
  - On the 4th byte (bc==3): write the assembled word to mem[ptr], ptr = (ptr+1) mod MEM_WORDS (wraps), remaining decrements, bc=0.
  - When remaining reaches 0 on that write: return to S_SERVE and pulse LdDone for 1 cycle the next cycle; Loading=0 in that same cycle.
- Read-after-load: the first fetch can be accepted in the cycle LdDone is high and returns the newly written data.
- Memory write is synchronous, one word per cycle maximum. The read is registered into the response register.

Decomposition:
- Shared package holds:
  - state encoding S_SERVE / S_LOAD.
  - NOP_INSTR constant.
  - error-cause encodings for future extension.
- One natural sub-module, imem_ld_assembler:
  - byte-to-word packer with byte counter, word pointer and remaining count.
  - outputs a write enable, write address and write data.
- The memory array and response register stay in the top.

Test Plan:
- Load LdBase=0x0, LdCount=2, bytes 13,05,10,00,93,00,20,00 -> LdDone pulses once. Then fetch 0x0 -> RspInstrF=0x00100513, RspErrF=0 one cycle after accept; fetch 0x4 -> 0x00200093.
- Back-pressure: accept 0x0, hold RspReadyF=0 for 3 cycles -> ReqReadyF=0 and response stable. RspReadyF=1 with a new request at 0x4 in the same cycle -> back-to-back responses with no bubble.
- Flush: response for 0x0 pending, FlushF=1 with a request at 0x4 the same cycle -> next response is 0x4's word only.
- Errors: fetch 0x2 -> RspErrF=1, RspInstrF=0x00000013. Fetch 4*MEM_WORDS -> same.
- Loader wrap: LdBase=4*(MEM_WORDS-1), LdCount=2 -> words land at MEM_WORDS-1 and 0. LdCount=0 -> LdDone the next cycle, Loading never asserted.
- Reset mid-load after 6 bytes -> state S_SERVE, Loading=0, RspValidF=0. Previously loaded complete words remain readable.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

    // Who owns the memory: fetch path or program loader.
    typedef enum logic {
        S_SERVE = 1'b0,
        S_LOAD  = 1'b1
    } state_e;

    // addi x0,x0,0 -- returned in place of data on an error response.
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Error causes; only the summary flag leaves the block for now.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_RSVD     = 2'd3
    } err_cause_e;

endpackage

// File: rtl/imem_ld_assembler.sv
// Loader byte packer: gathers little-endian bytes into words and walks the
// word pointer through memory, counting down the words still to load.
module imem_ld_assembler
    import imem_responder_pkg::*;
#(
    parameter int unsigned AW    = 13,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic [AW-1:0]    i_base,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    output logic             o_we,
    output logic [AW-1:0]    o_waddr,
    output logic [31:0]      o_wdata,
    output logic             o_last
);

    logic [1:0]       r_bc;
    logic [AW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_rem;
    logic [23:0]      r_word;

    // Byte counter, pointer, remaining count and partial-word lanes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bc   <= 2'd0;
            r_ptr  <= '0;
            r_rem  <= '0;
            r_word <= '0;
        end else if (i_start) begin
            r_ptr <= i_base;
            r_rem <= i_count;
            r_bc  <= 2'd0;
        end else if (i_byte_valid) begin
            if (r_bc == 2'd3) begin
                r_bc  <= 2'd0;
                r_ptr <= r_ptr + AW'(1);
                r_rem <= r_rem - CNT_W'(1);
            end else begin
                r_bc <= r_bc + 2'd1;
                case (r_bc)
                    2'd0:    r_word[7:0]   <= i_byte;
                    2'd1:    r_word[15:8]  <= i_byte;
                    default: r_word[23:16] <= i_byte;
                endcase
            end
        end
    end

    // The 4th byte goes straight into the write data, so the word is
    // written in the same cycle it completes.
    always_comb begin
        o_we    = i_byte_valid && (r_bc == 2'd3);
        o_waddr = r_ptr;
        o_wdata = {i_byte, r_word};
        o_last  = o_we && (r_rem == CNT_W'(1));
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one-cycle fetch responses through a single
// back-pressured output register, plus a byte-stream boot loader.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 8192,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ReqValidF,
    input  logic [31:0]      ReqAddrF,
    output logic             ReqReadyF,
    input  logic             FlushF,
    output logic             RspValidF,
    output logic [31:0]      RspInstrF,
    output logic             RspErrF,
    input  logic             RspReadyF,
    input  logic             LdStart,
    input  logic [31:0]      LdBase,
    input  logic [CNT_W-1:0] LdCount,
    input  logic             LdValid,
    input  logic [7:0]       LdByte,
    output logic             LdReady,
    output logic             Loading,
    output logic             LdDone
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    state_e        r_state, w_state_d;
    logic          r_ld_done, w_ld_done_d;
    logic          r_rsp_valid, r_rsp_err;
    logic [31:0]   r_rsp_instr;
    logic [31:0]   r_mem [MEM_WORDS];

    logic          w_ld_start, w_accept, w_err;
    logic          w_byte_valid, w_we, w_last;
    logic [AW-1:0] w_idx, w_waddr;
    logic [31:0]   w_wdata;
    err_cause_e    w_err_cause;
    logic          w_unused_ld_base;

    assign w_unused_ld_base = ^{LdBase[1:0], LdBase[31:AW+2]};

    // Request decode, handshake and error classification.
    always_comb begin
        w_ld_start   = LdStart && (r_state == S_SERVE);
        ReqReadyF    = (r_state == S_SERVE) && !LdStart &&
                       (!r_rsp_valid || RspReadyF || FlushF);
        w_accept     = ReqValidF && ReqReadyF;
        w_idx        = ReqAddrF[AW+1:2];
        w_byte_valid = LdValid && (r_state == S_LOAD);
        if (ReqAddrF[1:0] != 2'b00) begin
            w_err_cause = ERR_MISALIGN;
        end else if (|ReqAddrF[31:AW+2]) begin
            w_err_cause = ERR_RANGE;
        end else begin
            w_err_cause = ERR_NONE;
        end
        w_err = (w_err_cause != ERR_NONE);
    end

    // Loader state register and done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_SERVE;
            r_ld_done <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_ld_done <= w_ld_done_d;
        end
    end

    // Next state: a zero-length load completes without leaving S_SERVE.
    always_comb begin
        w_state_d   = r_state;
        w_ld_done_d = 1'b0;
        unique case (r_state)
            S_SERVE: begin
                if (w_ld_start) begin
                    if (LdCount == '0) begin
                        w_ld_done_d = 1'b1;
                    end else begin
                        w_state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_state_d   = S_SERVE;
                    w_ld_done_d = 1'b1;
                end
            end
            default: w_state_d = S_SERVE;
        endcase
    end

    imem_ld_assembler #(
        .AW    (AW),
        .CNT_W (CNT_W)
    ) u_ld_asm (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (w_ld_start),
        .i_base       (LdBase[AW+1:2]),
        .i_count      (LdCount),
        .i_byte_valid (w_byte_valid),
        .i_byte       (LdByte),
        .o_we         (w_we),
        .o_waddr      (w_waddr),
        .o_wdata      (w_wdata),
        .o_last       (w_last)
    );

    // Memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Output register: load on accept, drain on ready/flush, else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= '0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_instr <= w_err ? NOP_INSTR : r_mem[w_idx];
            r_rsp_err   <= w_err;
        end else if (RspReadyF || FlushF) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign RspValidF = r_rsp_valid;
    assign RspInstrF = r_rsp_instr;
    assign RspErrF   = r_rsp_err;
    assign LdReady   = (r_state == S_LOAD);
    assign Loading   = (r_state == S_LOAD);
    assign LdDone    = r_ld_done;

endmodule
